// File: rtl/conf_readback_pkg.sv
// ---------------------------------------------------------------------------
// ConfReadbackPkg
// Shared constants and types for the configuration readback path.
//   - Register file geometry (register width, register count, index width)
//   - Upstream word geometry: {code, idx, value}, with the field offsets
//   - Word codes that tell the PC-side merger where a dump ends
//   - Packed word type plus a helper that assembles one word
// ---------------------------------------------------------------------------
package ConfReadbackPkg;

  localparam int NCONF  = 16;
  localparam int NREG   = 32;
  localparam int NIDX   = 5;
  localparam int NCODE  = 3;
  localparam int NPCOUT = NCODE + NIDX + NCONF;

  // Field offsets inside one upstream word, LSB first.
  localparam int VALUE_LSB = 0;
  localparam int IDX_LSB   = VALUE_LSB + NCONF;
  localparam int CODE_LSB  = IDX_LSB + NIDX;

  // CODE_NONE is reserved and never emitted by this block.
  localparam logic [NCODE-1:0] CODE_NONE = 3'b000;
  localparam logic [NCODE-1:0] CODE_DATA = 3'b001;
  localparam logic [NCODE-1:0] CODE_LAST = 3'b010;

  typedef struct packed {
    logic [NCODE-1:0] code;
    logic [NIDX-1:0]  idx;
    logic [NCONF-1:0] value;
  } out_word_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Assembles one upstream word from its three fields.
  function automatic out_word_t make_word(input logic [NCODE-1:0] code,
                                          input logic [NIDX-1:0]  idx,
                                          input logic [NCONF-1:0] value);
    out_word_t w;
    w.code  = code;
    w.idx   = idx;
    w.value = value;
    return w;
  endfunction

endpackage

// File: rtl/conf_readback_snapshot.sv
// ---------------------------------------------------------------------------
// conf_snapshot
// Holds a frozen copy of the whole configuration register file so that a
// dump in progress always reports the values seen at the moment the request
// was accepted, no matter how the live registers change afterwards.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   load        - capture strobe; copies every register on the same edge
//   reg_in      - live register file [NREG-1:0][NCONF-1:0]
//   rd_idx      - register index to read from the frozen copy
//   rd_value    - frozen register value, zero for indices past NREG-1
// ---------------------------------------------------------------------------
module conf_snapshot
  import ConfReadbackPkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NREG-1:0][NCONF-1:0]  reg_in,
  input  logic [NIDX-1:0]             rd_idx,
  output logic [NCONF-1:0]            rd_value
);

  logic [NREG-1:0][NCONF-1:0] snap_q;
  logic [NREG-1:0][NCONF-1:0] snap_d;

  // The frozen copy only changes on a load strobe; otherwise it holds.
  always_comb begin
    snap_d = snap_q;
    if (load) begin
      snap_d = reg_in;
    end
  end

  // Snapshot storage, cleared on reset so a fresh dump never shows stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Read mux. The range guard only matters if the index width can address
  // more registers than exist; with a full power-of-two file it is always true.
  always_comb begin
    rd_value = '0;
    if (int'(rd_idx) < NREG) begin
      rd_value = snap_q[rd_idx];
    end
  end

endmodule

// File: rtl/conf_readback.sv
// ---------------------------------------------------------------------------
// conf_readback
// Streams a coherent snapshot of the configuration register file back toward
// the PC. Each request names an inclusive index range; every register in the
// range leaves as one upstream word {code, idx, value}, the final one tagged
// CODE_LAST so the host knows the dump is complete.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   conf_reg_out  - live register file [NREG-1:0][NCONF-1:0]
//   req_d/v/a     - request channel, req_d = {last_idx, first_idx}
//   out_d/v/a     - upstream word channel, out_d = {code, idx, value}
// A transfer on either channel happens on a rising edge with v and a high.
// ---------------------------------------------------------------------------
module conf_readback
  import ConfReadbackPkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREG-1:0][NCONF-1:0]  conf_reg_out,
  input  logic [2*NIDX-1:0]           req_d,
  input  logic                        req_v,
  output logic                        req_a,
  output logic [NPCOUT-1:0]           out_d,
  output logic                        out_v,
  input  logic                        out_a
);

  state_t          state_q, state_d;
  logic [NIDX-1:0] cur_q, cur_d;
  logic [NIDX-1:0] last_q, last_d;

  logic [NIDX-1:0] first_idx;
  logic [NIDX-1:0] last_idx;
  logic            snap_load;
  logic [NCONF-1:0] snap_value;
  out_word_t       word;

  assign first_idx = req_d[NIDX-1:0];
  assign last_idx  = req_d[2*NIDX-1:NIDX];

  conf_snapshot u_snapshot (
    .clk      (clk),
    .reset    (reset),
    .load     (snap_load),
    .reg_in   (conf_reg_out),
    .rd_idx   (cur_q),
    .rd_value (snap_value)
  );

  // Next-state and output logic. In IDLE a valid request is accepted at
  // once: the snapshot is captured and the range latched, with an inverted
  // range collapsed to the single register first_idx. In SEND the current
  // word is presented from registered state only, and each accepted word
  // either advances the index or, on the last one, returns to IDLE. Since
  // req_a is low throughout SEND, a new request naturally waits one bubble.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    snap_load = 1'b0;
    req_a     = 1'b0;
    out_v     = 1'b0;
    word      = '0;

    case (state_q)
      ST_IDLE: begin
        req_a = req_v;
        if (req_v) begin
          snap_load = 1'b1;
          cur_d     = first_idx;
          last_d    = (last_idx < first_idx) ? first_idx : last_idx;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        out_v = 1'b1;
        word  = make_word((cur_q == last_q) ? CODE_LAST : CODE_DATA,
                          cur_q, snap_value);
        if (out_a) begin
          if (cur_q == last_q) begin
            state_d = ST_IDLE;
          end else begin
            cur_d = cur_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_d = word;

  // State, index and range registers. Reset drops any dump in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_conf_readback.sv
// ---------------------------------------------------------------------------
// tb_conf_readback
// Self-checking bench for conf_readback. Expected words come from a simple
// model: at acceptance the register file is copied, and the dump is the list
// of indices first..max(first,last), each word built arithmetically as
// code*2^21 + idx*2^16 + value with the final word coded as "last".
// ---------------------------------------------------------------------------
module tb_conf_readback;
  import ConfReadbackPkg::*;

  logic                        clk;
  logic                        reset;
  logic [NREG-1:0][NCONF-1:0]  conf_regs;
  logic [2*NIDX-1:0]           req_d;
  logic                        req_v;
  logic                        req_a;
  logic [NPCOUT-1:0]           out_d;
  logic                        out_v;
  logic                        out_a;

  int pass_count;
  int check_count;

  typedef struct {
    int first;
    int last;
    int duty;
    int exp_words;
  } vec_t;

  vec_t vecs[7];

  conf_readback dut (
    .clk          (clk),
    .reset        (reset),
    .conf_reg_out (conf_regs),
    .req_d        (req_d),
    .req_v        (req_v),
    .req_a        (req_a),
    .out_d        (out_d),
    .out_v        (out_v),
    .out_a        (out_a)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against the model's value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives the request and output-accept inputs.
  task automatic applyStimulus(input int first, input int last, input logic valid,
                               input logic accept);
    logic [31:0] f;
    logic [31:0] l;
    f = first;
    l = last;
    req_d = {l[NIDX-1:0], f[NIDX-1:0]};
    req_v = valid;
    out_a = accept;
  endtask

  function automatic logic [31:0] model_word(input int code, input int idx, input int value);
    return code * (1 << 21) + idx * (1 << 16) + value;
  endfunction

  // Runs one complete dump starting just after a rising edge with the DUT idle.
  // mutate changes register 2 one cycle after acceptance; chain keeps a second
  // request pending throughout the dump so the next call starts in the bubble.
  task automatic runDump(input int first, input int last, input int duty,
                         input bit mutate, input bit chain, input int n_first,
                         input int n_last, output int words);
    int          snap_model[NREG];
    logic [31:0] exp_q[$];
    int          hi;
    int          cycles;
    logic        acc;

    applyStimulus(first, last, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("req_a_accept", {31'b0, req_a}, 32'd1);
    checkOutput("out_v_pre_dump", {31'b0, out_v}, 32'd0);
    @(posedge clk);
    for (int i = 0; i < NREG; i++) snap_model[i] = int'(conf_regs[i]);
    #1;
    if (mutate) conf_regs[2] = 16'hBEEF;
    if (chain) applyStimulus(n_first, n_last, 1'b1, 1'b0);
    else       applyStimulus(first, last, 1'b0, 1'b0);

    hi = (last < first) ? first : last;
    for (int i = first; i <= hi; i++) begin
      exp_q.push_back(model_word((i == hi) ? 2 : 1, i, snap_model[i]));
    end

    words  = 0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 2000) begin
      acc   = ($urandom_range(99) < duty);
      out_a = acc;
      @(negedge clk);
      checkOutput("out_v_in_dump", {31'b0, out_v}, 32'd1);
      checkOutput("out_d_word", {8'b0, out_d}, exp_q[0]);
      if (chain) checkOutput("req_a_held_off", {31'b0, req_a}, 32'd0);
      @(posedge clk);
      if (acc) begin
        void'(exp_q.pop_front());
        words++;
      end
      #1;
      cycles++;
    end
    out_a = 1'b0;
    if (exp_q.size() > 0) begin
      checkOutput("dump_timeout", exp_q.size(), 32'd0);
    end

    if (!chain) begin
      @(negedge clk);
      checkOutput("out_v_after_dump", {31'b0, out_v}, 32'd0);
      checkOutput("req_a_after_dump", {31'b0, req_a}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int words;

    pass_count  = 0;
    check_count = 0;
    for (int i = 0; i < NREG; i++) conf_regs[i] = NCONF'($urandom);

    vecs[0] = '{first: 1,  last: 3,  duty: 100, exp_words: 3};
    vecs[1] = '{first: 7,  last: 2,  duty: 100, exp_words: 1};
    vecs[2] = '{first: 0,  last: 31, duty: 30,  exp_words: 32};
    vecs[3] = '{first: 31, last: 31, duty: 100, exp_words: 1};
    vecs[4] = '{first: 5,  last: 5,  duty: 60,  exp_words: 1};
    vecs[5] = '{first: 10, last: 20, duty: 50,  exp_words: 11};
    vecs[6] = '{first: 30, last: 0,  duty: 40,  exp_words: 1};

    // Reset state.
    reset = 1'b1;
    applyStimulus(0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_v", {31'b0, out_v}, 32'd0);
    checkOutput("reset_req_a", {31'b0, req_a}, 32'd0);
    checkOutput("reset_out_d", {8'b0, out_d}, 32'd0);
    @(posedge clk);
    #1;

    // Table-driven dumps, randomising the register file between them.
    for (int v = 0; v < 7; v++) begin
      runDump(vecs[v].first, vecs[v].last, vecs[v].duty, 1'b0, 1'b0, 0, 0, words);
      checkOutput("word_count", words, vecs[v].exp_words);
      for (int i = 0; i < NREG; i++) conf_regs[i] = NCONF'($urandom);
    end

    // Coherency: register 2 changes after acceptance, shows up only next dump.
    conf_regs[2] = 16'h1234;
    runDump(1, 3, 100, 1'b1, 1'b0, 0, 0, words);
    checkOutput("coherent_count", words, 32'd3);
    checkOutput("reg2_changed", {16'b0, conf_regs[2]}, 32'h0000BEEF);
    runDump(2, 2, 100, 1'b0, 1'b0, 0, 0, words);
    checkOutput("second_dump_count", words, 32'd1);

    // Request held during SEND, accepted in the single bubble cycle.
    runDump(0, 4, 70, 1'b0, 1'b1, 6, 8, words);
    checkOutput("chain_first_count", words, 32'd5);
    runDump(6, 8, 100, 1'b0, 1'b0, 0, 0, words);
    checkOutput("chain_second_count", words, 32'd3);

    // Reset for one cycle after five words of a full dump.
    applyStimulus(0, 31, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(0, 31, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("pre_reset_word", {8'b0, out_d}, model_word(1, i, int'(conf_regs[i])));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_a = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_v", {31'b0, out_v}, 32'd0);
    checkOutput("abort_req_a", {31'b0, req_a}, 32'd0);
    @(posedge clk);
    #1;
    runDump(0, 0, 100, 1'b0, 1'b0, 0, 0, words);
    checkOutput("post_reset_count", words, 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
